board_game_ctrl: RTL and testbench

BOARD_GAME_CTRL -- requirements
Module: board_game_ctrl

---
 rtl/board_game_pkg.sv | 22 ++
 rtl/board_line_check.sv | 45 ++++
 rtl/board_game_ctrl.sv | 133 +++++++++++++
 tb/tb_board_game_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/board_game_pkg.sv
// Shared encodings for the board game controller: FSM states, cell marks, winner codes.
package board_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    CHECK = 3'd2,
    WIN   = 3'd3,
    DRAW  = 3'd4
  } state_t;

  // Cell contents
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  // Winner codes
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage

// File: rtl/board_line_check.sv
// Combinational line evaluator: flags any complete row/column/diagonal and a full board.
module board_line_check #(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0] board,
  output logic             win,
  output logic             full
);
  import board_game_pkg::*;

  logic [N*N-1:0][1:0] c;
  logic [N*N-1:0]      occ;
  logic [N-1:0]        row_win, col_win;
  logic [N-1:0]        d0_eq, d1_eq;
  logic [1:0]          diag_win;

  assign c = board;

  for (genvar i = 0; i < N*N; i++) begin : g_occ
    assign occ[i] = (c[i] != EMPTY);
  end

  // A line wins when its first cell is occupied and every cell matches the first.
  for (genvar a = 0; a < N; a++) begin : g_line
    logic [N-1:0] r_eq, c_eq;
    for (genvar b = 0; b < N; b++) begin : g_cell
      assign r_eq[b] = (c[a*N+b] == c[a*N]);
      assign c_eq[b] = (c[b*N+a] == c[a]);
    end
    assign row_win[a] = occ[a*N] && (&r_eq);
    assign col_win[a] = occ[a]   && (&c_eq);
  end

  for (genvar b = 0; b < N; b++) begin : g_diag
    assign d0_eq[b] = (c[b*N+b]       == c[0]);
    assign d1_eq[b] = (c[b*N+N-1-b]   == c[N-1]);
  end

  assign diag_win[0] = occ[0]   && (&d0_eq);
  assign diag_win[1] = occ[N-1] && (&d1_eq);

  assign win  = (|row_win) || (|col_win) || (|diag_win);
  assign full = &occ;

endmodule

// File: rtl/board_game_ctrl.sv
// Two-player N x N line game controller with per-turn countdown and auto-move on timeout.
module board_game_ctrl #(
  parameter int N        = 3,
  parameter int CLK_HZ   = 50_000_000,
  parameter int TURN_SEC = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    first_p2,
  input  logic                    move_valid,
  input  logic [$clog2(N*N)-1:0]  move_idx,
  input  logic                    ack_clear,
  output logic [2*N*N-1:0]        board,
  output logic [2:0]              state,
  output logic                    turn,
  output logic [5:0]              sec_left,
  output logic                    move_ok,
  output logic                    move_err,
  output logic                    auto_move,
  output logic [1:0]              winner
);
  import board_game_pkg::*;

  localparam int CELLS = N*N;
  localparam int IW    = $clog2(CELLS);
  localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  state_t              state_q, state_d;
  logic [CELLS-1:0][1:0] cells_q;
  logic                turn_q;
  logic [5:0]          sec_q;
  logic [PW-1:0]       presc_q;
  logic [1:0]          winner_q;
  logic                ok_q, err_q, auto_q;

  logic                line_win, board_full;
  logic                tick, in_range, accept, reject, timeout;
  logic [1:0]          mark;
  logic [IW-1:0]       auto_idx;

  board_line_check #(.N(N)) u_line (
    .board (cells_q),
    .win   (line_win),
    .full  (board_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; undefined encodings fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:  state_d = start ? TURN : IDLE;
      TURN:  state_d = (accept || timeout) ? CHECK : TURN;
      CHECK: state_d = line_win ? WIN : (board_full ? DRAW : TURN);
      WIN:   state_d = ack_clear ? IDLE : WIN;
      DRAW:  state_d = ack_clear ? IDLE : DRAW;
      default: state_d = IDLE;
    endcase
  end

  // Move arbitration: a legal move beats a same-cycle timeout; the auto-move
  // target is the lowest-index empty cell.
  always_comb begin
    mark     = turn_q ? P2 : P1;
    tick     = (state_q == TURN) && (presc_q == PW'(CLK_HZ - 1));
    in_range = (int'(move_idx) < CELLS);
    accept   = (state_q == TURN) && move_valid && in_range &&
               (cells_q[move_idx] == EMPTY);
    reject   = move_valid && !accept;
    timeout  = tick && (sec_q == 6'd1) && !accept;
    auto_idx = '0;
    for (int i = CELLS-1; i >= 0; i--)
      if (cells_q[i] == EMPTY) auto_idx = IW'(i);
  end

  // Datapath: board, turn, timer, winner and the status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cells_q  <= '0;
      turn_q   <= 1'b0;
      sec_q    <= 6'(TURN_SEC);
      presc_q  <= '0;
      winner_q <= WINNER_NONE;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      auto_q   <= 1'b0;
    end else begin
      ok_q   <= accept;
      err_q  <= reject;
      auto_q <= timeout;
      case (state_q)
        IDLE: if (start) begin
          cells_q  <= '0;
          turn_q   <= first_p2;
          sec_q    <= 6'(TURN_SEC);
          presc_q  <= '0;
          winner_q <= WINNER_NONE;
        end
        TURN: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (tick) sec_q <= sec_q - 6'd1;
          if (accept)       cells_q[move_idx] <= mark;
          else if (timeout) cells_q[auto_idx] <= mark;
        end
        CHECK: begin
          if (line_win) winner_q <= turn_q ? WINNER_P2 : WINNER_P1;
          else if (!board_full) begin
            turn_q  <= ~turn_q;
            sec_q   <= 6'(TURN_SEC);
            presc_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign board     = cells_q;
  assign state     = state_q;
  assign turn      = turn_q;
  assign sec_left  = sec_q;
  assign winner    = winner_q;
  assign move_ok   = ok_q;
  assign move_err  = err_q;
  assign auto_move = auto_q;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Directed bench for board_game_ctrl with N=3, CLK_HZ=4, TURN_SEC=3.
module tb_board_game_ctrl;
  localparam int N = 3;
  localparam int CLK_HZ = 4;
  localparam int TURN_SEC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        first_p2 = 1'b0;
  logic        move_valid = 1'b0;
  logic [3:0]  move_idx = '0;
  logic        ack_clear = 1'b0;
  logic [17:0] board;
  logic [2:0]  state;
  logic        turn;
  logic [5:0]  sec_left;
  logic        move_ok, move_err, auto_move;
  logic [1:0]  winner;

  int total = 0;
  int bad = 0;

  int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int seq_win [9] = '{0, 1, 2, 3, 5, 4, 7, 6, 8};

  always #5 clk = ~clk;

  board_game_ctrl #(.N(N), .CLK_HZ(CLK_HZ), .TURN_SEC(TURN_SEC)) dut (
    .clk(clk), .rst(rst), .start(start), .first_p2(first_p2),
    .move_valid(move_valid), .move_idx(move_idx), .ack_clear(ack_clear),
    .board(board), .state(state), .turn(turn), .sec_left(sec_left),
    .move_ok(move_ok), .move_err(move_err), .auto_move(auto_move),
    .winner(winner)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mv(input int idx);
    move_valid = 1'b1;
    move_idx   = 4'(idx);
    step();
    move_valid = 1'b0;
  endtask

  task automatic begin_game(input logic p2);
    start    = 1'b1;
    first_p2 = p2;
    step();
    start    = 1'b0;
  endtask

  initial begin
    // Reset wins over start/move/ack in the same cycle
    start = 1'b1; move_valid = 1'b1; ack_clear = 1'b1;
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_board", 32'(board), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_sec", 32'(sec_left), 32'd3);
    chk("rst_pulses", 32'({move_ok, move_err, auto_move}), 32'd0);
    rst = 1'b0; start = 1'b0; move_valid = 1'b0; ack_clear = 1'b0;

    // Move outside TURN only raises move_err
    mv(0);
    chk("idle_err", 32'(move_err), 32'd1);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_board", 32'(board), 32'd0);
    step();
    chk("err_pulse_end", 32'(move_err), 32'd0);

    // Row-0 win for P1
    begin_game(1'b0);
    chk("start_state", 32'(state), 32'd1);
    chk("start_turn", 32'(turn), 32'd0);
    chk("start_sec", 32'(sec_left), 32'd3);
    mv(0);
    chk("m0_board", 32'(board), 32'h1);
    chk("m0_ok", 32'(move_ok), 32'd1);
    chk("m0_state", 32'(state), 32'd2);
    step();
    chk("m0_next_state", 32'(state), 32'd1);
    chk("m0_next_turn", 32'(turn), 32'd1);
    chk("m0_next_sec", 32'(sec_left), 32'd3);
    mv(0);
    chk("occ_err", 32'(move_err), 32'd1);
    chk("occ_board", 32'(board), 32'h1);
    chk("occ_turn", 32'(turn), 32'd1);
    chk("occ_sec", 32'(sec_left), 32'd3);
    chk("occ_state", 32'(state), 32'd1);
    mv(9);
    chk("range_err", 32'(move_err), 32'd1);
    chk("range_state", 32'(state), 32'd1);
    mv(3); step();
    mv(1); step();
    mv(4); step();
    mv(2);
    chk("win_pre_board", 32'(board), 32'h295);
    chk("win_pre_state", 32'(state), 32'd2);
    step();
    chk("win_state", 32'(state), 32'd3);
    chk("win_winner", 32'(winner), 32'd1);
    chk("win_board", 32'(board), 32'h295);
    step();
    chk("win_hold", 32'(state), 32'd3);
    ack_clear = 1'b1; step(); ack_clear = 1'b0;
    chk("ack_state", 32'(state), 32'd0);
    chk("ack_board", 32'(board), 32'h295);
    chk("ack_winner", 32'(winner), 32'd1);

    // Timeout auto-move into lowest empty cell
    begin_game(1'b0);
    chk("restart_board", 32'(board), 32'd0);
    chk("restart_winner", 32'(winner), 32'd0);
    repeat (11) step();
    chk("pre_to_sec", 32'(sec_left), 32'd1);
    chk("pre_to_board", 32'(board), 32'd0);
    chk("pre_to_auto", 32'(auto_move), 32'd0);
    step();
    chk("to_auto", 32'(auto_move), 32'd1);
    chk("to_board", 32'(board), 32'h1);
    chk("to_sec", 32'(sec_left), 32'd0);
    chk("to_state", 32'(state), 32'd2);
    step();
    chk("to_turn", 32'(turn), 32'd1);
    chk("to_sec_reload", 32'(sec_left), 32'd3);
    chk("to_state_turn", 32'(state), 32'd1);
    chk("to_auto_end", 32'(auto_move), 32'd0);

    // Move coinciding with the final tick beats the timeout
    repeat (11) step();
    chk("race_pre_sec", 32'(sec_left), 32'd1);
    mv(5);
    chk("race_board", 32'(board), 32'h801);
    chk("race_auto", 32'(auto_move), 32'd0);
    chk("race_ok", 32'(move_ok), 32'd1);
    step();
    chk("race_turn", 32'(turn), 32'd0);
    chk("race_state", 32'(state), 32'd1);

    // Full board with no line -> DRAW
    rst = 1'b1; step(); rst = 1'b0;
    begin_game(1'b0);
    for (int k = 0; k < 9; k++) begin
      mv(seq_draw[k]);
      chk($sformatf("draw_ok%0d", k), 32'(move_ok), 32'd1);
      step();
    end
    chk("draw_state", 32'(state), 32'd4);
    chk("draw_winner", 32'(winner), 32'd0);
    chk("draw_board", 32'(board), 32'h16A59);

    // Ninth move fills the board and completes column 2 -> WIN
    rst = 1'b1; step(); rst = 1'b0;
    begin_game(1'b0);
    for (int k = 0; k < 9; k++) begin
      mv(seq_win[k]);
      step();
    end
    chk("fullwin_state", 32'(state), 32'd3);
    chk("fullwin_winner", 32'(winner), 32'd1);
    chk("fullwin_board", 32'(board), 32'h16699);

    // P2 first, then reset while in CHECK
    rst = 1'b1; step(); rst = 1'b0;
    begin_game(1'b1);
    chk("p2_turn", 32'(turn), 32'd1);
    mv(4);
    chk("p2_board", 32'(board), 32'h200);
    chk("p2_check", 32'(state), 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("chkrst_state", 32'(state), 32'd0);
    chk("chkrst_board", 32'(board), 32'd0);
    chk("chkrst_sec", 32'(sec_left), 32'd3);
    chk("chkrst_ok", 32'(move_ok), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
